bus_share_arbiter: RTL and testbench

- Round-robin arbiter that shares one 16-bit datapath bus among four requesters.
- Generates the 2-bit select (ctrlSlct) for the 4:1 16-bit MUX_TwoBit and registers the selected word onto a shared bus output.
- Sits between the register/ALU/memory/immediate sources and the single shared bus input.
- Bounds bus tenure with a programmable hold limit so that no requester can starve the others.

---
 rtl/bus_share_arbiter.sv | 125 ++++++++++++
 tb/tb_bus_share_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bus_share_arbiter.sv
// bus_share_arbiter: round-robin owner of a shared WIDTH-bit bus for four requesters,
// with a programmable tenure limit and a registered bus word and select.
module bus_share_arbiter #(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic             CLK,
    input  logic             resetN,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    output logic [3:0]       grant,
    output logic [1:0]       ctrlSlct,
    output logic [WIDTH-1:0] busOut,
    output logic             busValid
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam bit             LIMITED   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nxt;
    logic [1:0]       owner_nxt, last_owner, last_owner_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic             xfer;
    logic [2:0]       pick;
    logic [3:0]       others;
    logic [WIDTH-1:0] in_sel;

    // Returns {found, index}: first set bit of cand at after+1, after+2, ... modulo 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] after);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = after + 2'(k);
            if (cand[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        unique case (ctrlSlct)
            2'd0:    in_sel = in1;
            2'd1:    in_sel = in2;
            2'd2:    in_sel = in3;
            default: in_sel = in4;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = ctrlSlct;
        last_owner_nxt = last_owner;
        hold_nxt       = hold_cnt;
        xfer           = 1'b0;
        pick           = 3'b000;
        others         = req & ~(4'b0001 << ctrlSlct);
        unique case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    pick           = rr_pick(req, last_owner);
                    state_nxt      = OWN;
                    owner_nxt      = pick[1:0];
                    last_owner_nxt = pick[1:0];
                    hold_nxt       = '0;
                end
            end
            OWN: begin
                if (!req[ctrlSlct]) begin
                    // Release wins over preemption: no transfer on this edge.
                    pick = rr_pick(req, ctrlSlct);
                    if (pick[2]) begin
                        owner_nxt      = pick[1:0];
                        last_owner_nxt = pick[1:0];
                        hold_nxt       = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    xfer = 1'b1;
                    if (LIMITED && hold_cnt == HOLD_LAST && others != 4'b0000) begin
                        pick           = rr_pick(others, ctrlSlct);
                        owner_nxt      = pick[1:0];
                        last_owner_nxt = pick[1:0];
                        hold_nxt       = '0;
                    end else if (LIMITED && hold_cnt != HOLD_LAST) begin
                        hold_nxt = hold_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            ctrlSlct   <= 2'd0;
            last_owner <= 2'd3;
            hold_cnt   <= '0;
            busOut     <= '0;
            busValid   <= 1'b0;
        end else begin
            state      <= state_nxt;
            ctrlSlct   <= owner_nxt;
            last_owner <= last_owner_nxt;
            hold_cnt   <= hold_nxt;
            busValid   <= xfer;
            if (xfer) busOut <= in_sel;
        end
    end

    // Grant is a pure decode of flops, so no input reaches an output combinationally.
    always_comb begin
        grant = (state == OWN) ? (4'b0001 << ctrlSlct) : 4'b0000;
    end

endmodule

// File: tb/tb_bus_share_arbiter.sv
// Directed self-checking bench for bus_share_arbiter with hand-computed expectations.
module tb_bus_share_arbiter;

    logic        CLK;
    logic        resetN;
    logic [3:0]  req;
    logic [15:0] in1, in2, in3, in4;
    logic [3:0]  grant;
    logic [1:0]  ctrlSlct;
    logic [15:0] busOut;
    logic        busValid;

    int n_cmp = 0;
    int n_bad = 0;

    bus_share_arbiter #(.WIDTH(16), .MAX_HOLD(4), .CNT_W(3)) dut (
        .CLK(CLK), .resetN(resetN), .req(req),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .grant(grant), .ctrlSlct(ctrlSlct), .busOut(busOut), .busValid(busValid)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        resetN = 1'b0;
        req    = 4'b0000;
        #2;
        resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b0;
        req    = 4'b0000;
        in1 = 16'd500; in2 = 16'd350; in3 = 16'd150; in4 = 16'd10;
        #3;

        // 1: reset values, single requester
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_slct", 32'(ctrlSlct), 32'd0);
        check("rst_bus", 32'(busOut), 32'd0);
        check("rst_valid", 32'(busValid), 32'd0);
        resetN = 1'b1;
        req = 4'b0001;
        tick();
        check("t1_grant", 32'(grant), 32'b0001);
        check("t1_slct", 32'(ctrlSlct), 32'd0);
        check("t1_valid0", 32'(busValid), 32'd0);
        tick();
        check("t1_bus", 32'(busOut), 32'd500);
        check("t1_valid1", 32'(busValid), 32'd1);
        req = 4'b0000;
        tick();
        check("t1_idle_grant", 32'(grant), 32'h0);
        check("t1_idle_valid", 32'(busValid), 32'd0);
        check("t1_idle_bus", 32'(busOut), 32'd500);
        check("t1_idle_slct", 32'(ctrlSlct), 32'd0);

        // 2: all request, each drops after one transfer
        apply_reset();
        req = 4'b1111;
        tick();
        check("t2_g0", 32'(grant), 32'b0001);
        tick();
        check("t2_b0", 32'(busOut), 32'd500);
        req = 4'b1110;
        tick();
        check("t2_g1", 32'(grant), 32'b0010);
        check("t2_hand_valid", 32'(busValid), 32'd0);
        tick();
        check("t2_b1", 32'(busOut), 32'd350);
        req = 4'b1100;
        tick();
        check("t2_g2", 32'(grant), 32'b0100);
        tick();
        check("t2_b2", 32'(busOut), 32'd150);
        req = 4'b1000;
        tick();
        check("t2_g3", 32'(grant), 32'b1000);
        check("t2_slct3", 32'(ctrlSlct), 32'd3);
        tick();
        check("t2_b3", 32'(busOut), 32'd10);
        req = 4'b0000;
        tick();
        check("t2_idle", 32'(grant), 32'h0);

        // 3: two persistent requesters alternate every MAX_HOLD transfers
        apply_reset();
        req = 4'b0011;
        tick();
        check("t3_first", 32'(grant), 32'b0001);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                check($sformatf("t3_bus_r%0d_%0d", r, i), 32'(busOut), (r % 2 == 0) ? 32'd500 : 32'd350);
                check($sformatf("t3_valid_r%0d_%0d", r, i), 32'(busValid), 32'd1);
                if (i == 3)
                    check($sformatf("t3_pre_r%0d", r), 32'(grant), (r % 2 == 0) ? 32'b0010 : 32'b0001);
                else
                    check($sformatf("t3_grant_r%0d_%0d", r, i), 32'(grant), (r % 2 == 0) ? 32'b0001 : 32'b0010);
            end
        end

        // 4: lone requester keeps the bus
        apply_reset();
        req = 4'b0100;
        tick();
        check("t4_grant0", 32'(grant), 32'b0100);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("t4_grant_%0d", i), 32'(grant), 32'b0100);
            check($sformatf("t4_bus_%0d", i), 32'(busOut), 32'd150);
            check($sformatf("t4_valid_%0d", i), 32'(busValid), 32'd1);
        end

        // 5: owner 2 releases with req=1001 -> round-robin picks 3
        req = 4'b1001;
        tick();
        check("t5_grant", 32'(grant), 32'b1000);
        check("t5_slct", 32'(ctrlSlct), 32'd3);
        check("t5_gap_valid", 32'(busValid), 32'd0);
        check("t5_gap_bus", 32'(busOut), 32'd150);
        tick();
        check("t5_bus", 32'(busOut), 32'd10);
        check("t5_valid", 32'(busValid), 32'd1);

        // 6: asynchronous reset mid-tenure
        apply_reset();
        req = 4'b0010;
        tick();
        check("t6_grant", 32'(grant), 32'b0010);
        tick();
        check("t6_bus", 32'(busOut), 32'd350);
        #2;
        resetN = 1'b0;
        #1;
        check("t6_async_grant", 32'(grant), 32'h0);
        check("t6_async_valid", 32'(busValid), 32'd0);
        check("t6_async_bus", 32'(busOut), 32'd0);
        check("t6_async_slct", 32'(ctrlSlct), 32'd0);
        #1;
        resetN = 1'b1;
        req = 4'b1010;
        tick();
        check("t6_restart_grant", 32'(grant), 32'b0010);
        check("t6_restart_slct", 32'(ctrlSlct), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
